// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS controller and its datapath:
// state encoding, opcode/funct constants, ALU operation codes, mux selects.
package mips_pkg;

  // Controller states; encoding 7 is unused and recovers to IDLE.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  // ALU operations understood by the datapath.
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  // Primary opcodes (IR[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  // R-type function codes (IR[5:0]).
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  // ALU operand B select.
  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  // Next-PC select.
  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;

  // True for the two opcodes that take the MEM state.
  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mips_ctrl_if.sv
// Controller <-> datapath bus: instruction fields and flags flow in,
// strobes and mux selects flow out.
interface mips_ctrl_if;
  import mips_pkg::*;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       ir_write;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  alu_op_t    alu_op;

  // Controller side.
  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, ir_write, reg_write, mem_read, mem_write,
           iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op
  );

  // Datapath side.
  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, ir_write, reg_write, mem_read, mem_write,
           iord, reg_dst, mem_to_reg, alu_src_a, alu_src_b, pc_src, alu_op
  );

endinterface

// File: rtl/mips_alu_dec.sv
// Combinational instruction decoder: picks the ALU operation for the
// EXEC step and flags whether opcode/funct form a supported instruction.
module mips_alu_dec
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output alu_op_t    alu_op,
  output logic       legal
);

  // Decode opcode (and funct for R-type) into ALU op and legality.
  // NOTE: both outputs are defaulted before the case so no path infers a latch.
  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD:   begin alu_op = ALU_ADD; legal = 1'b1; end
          F_SUB:   begin alu_op = ALU_SUB; legal = 1'b1; end
          F_AND:   begin alu_op = ALU_AND; legal = 1'b1; end
          F_OR:    begin alu_op = ALU_OR;  legal = 1'b1; end
          F_SLT:   begin alu_op = ALU_SLT; legal = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      OP_BEQ:  begin alu_op = ALU_SUB; legal = 1'b1; end
      OP_ADDI,
      OP_LW,
      OP_SW,
      OP_J,
      OP_HALT: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_ctrl.sv
// Multicycle MIPS control unit. A single state register walks each
// instruction through FETCH/DECODE/EXEC/MEM/WB; datapath strobes are
// decoded combinationally from the state and the live datapath inputs so
// that memory-ready handshakes take effect in the same cycle.
module mips_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  mips_ctrl_if.master      bus,
  output logic [2:0]       state,
  output logic             halted,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  state_t  state_q;
  state_t  state_d;
  logic    retire;
  logic    set_err;
  alu_op_t dec_alu_op;
  logic    dec_legal;
  logic    is_rtype;

  mips_alu_dec u_alu_dec (
    .opcode (bus.opcode),
    .funct  (bus.funct),
    .alu_op (dec_alu_op),
    .legal  (dec_legal)
  );

  assign is_rtype = (bus.opcode == OP_RTYPE);
  assign state    = state_q;
  assign halted   = (state_q == S_HALT);

  // Next-state, retirement and datapath strobe decode.
  always_comb begin
    state_d        = state_q;
    retire         = 1'b0;
    set_err        = 1'b0;
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.iord       = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_REG;
    bus.pc_src     = PC_ALU;
    bus.alu_op     = ALU_ADD;

    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end

      S_FETCH: begin
        // Read at PC; on completion latch IR and advance PC by 4.
        bus.mem_read = 1'b1;
        bus.iord     = 1'b0;
        if (bus.mem_ready) begin
          bus.ir_write  = 1'b1;
          bus.pc_write  = 1'b1;
          bus.alu_src_a = 1'b0;
          bus.alu_src_b = SRCB_FOUR;
          bus.pc_src    = PC_ALU;
          state_d       = S_DECODE;
        end
      end

      S_DECODE: begin
        if (bus.opcode == OP_HALT) begin
          state_d = S_HALT;
        end else if (!dec_legal) begin
          state_d = S_HALT;
          set_err = 1'b1;
        end else if (bus.opcode == OP_J) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = PC_JUMP;
          retire       = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = dec_alu_op;
        if (is_rtype) begin
          bus.alu_src_b = SRCB_REG;
          state_d       = S_WB;
        end else if (bus.opcode == OP_ADDI) begin
          bus.alu_src_b = SRCB_IMM;
          state_d       = S_WB;
        end else if (is_mem_op(bus.opcode)) begin
          bus.alu_src_b = SRCB_IMM;
          state_d       = S_MEM;
        end else if (bus.opcode == OP_BEQ) begin
          bus.alu_src_b = SRCB_REG;
          bus.pc_src    = PC_BRANCH;
          bus.pc_write  = bus.zero;
          retire        = 1'b1;
        end else begin
          // Only reachable if IR changed under the controller.
          state_d = S_IDLE;
        end
      end

      S_MEM: begin
        // Access held at the computed address until memory completes.
        bus.iord = 1'b1;
        if (bus.opcode == OP_LW) begin
          bus.mem_read = 1'b1;
          if (bus.mem_ready) state_d = S_WB;
        end else if (bus.opcode == OP_SW) begin
          bus.mem_write = 1'b1;
          if (bus.mem_ready) retire = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.reg_dst    = is_rtype;
        bus.mem_to_reg = (bus.opcode == OP_LW);
        retire         = 1'b1;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The run switch is only sampled at instruction boundaries.
    if (retire) state_d = start ? S_FETCH : S_IDLE;
  end

  // State register, retired-instruction counter and sticky error flag.
  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      instr_count <= '0;
      err         <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire)  instr_count <= instr_count + CNT_W'(1);
      if (set_err) err         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_ctrl.sv
// Directed testbench for mips_ctrl. A default-width instance is checked
// cycle by cycle; a 4-bit-counter instance shares its stimulus and is used
// for the counter wrap check.
module tb_mips_ctrl;
  import mips_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  state;
  logic        halted;
  logic        err;
  logic [15:0] instr_count;
  logic [2:0]  state4;
  logic        halted4;
  logic        err4;
  logic [3:0]  count4;

  int total;
  int bad;
  int exp_cnt;

  // Strobe bit masks in the order {pc_write, ir_write, reg_write, mem_read,
  // mem_write, iord, reg_dst, mem_to_reg, alu_src_a}.
  localparam logic [8:0] B_PCW  = 9'b100000000;
  localparam logic [8:0] B_IRW  = 9'b010000000;
  localparam logic [8:0] B_RW   = 9'b001000000;
  localparam logic [8:0] B_MR   = 9'b000100000;
  localparam logic [8:0] B_MW   = 9'b000010000;
  localparam logic [8:0] B_IORD = 9'b000001000;
  localparam logic [8:0] B_RD   = 9'b000000100;
  localparam logic [8:0] B_M2R  = 9'b000000010;
  localparam logic [8:0] B_ASA  = 9'b000000001;
  localparam logic [8:0] B_NONE = 9'b000000000;

  mips_ctrl_if bus ();
  mips_ctrl_if bus4 ();

  assign bus4.opcode    = bus.opcode;
  assign bus4.funct     = bus.funct;
  assign bus4.zero      = bus.zero;
  assign bus4.mem_ready = bus.mem_ready;

  mips_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus),
    .state       (state),
    .halted      (halted),
    .err         (err),
    .instr_count (instr_count)
  );

  mips_ctrl #(.CNT_W(4)) dut4 (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .bus         (bus4),
    .state       (state4),
    .halted      (halted4),
    .err         (err4),
    .instr_count (count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed {state, strobes, alu_src_b, pc_src, alu_op}.
  function automatic logic [18:0] obs();
    return {state, bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_read,
            bus.mem_write, bus.iord, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
            bus.alu_src_b, bus.pc_src, bus.alu_op};
  endfunction

  function automatic logic [18:0] ex(input state_t st, input logic [8:0] s,
                                     input logic [1:0] sb, input logic [1:0] ps,
                                     input alu_op_t op);
    return {st, s, sb, ps, op};
  endfunction

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    total++;
    if (obs() !== 19'h0 || instr_count !== 16'd0 || err !== 1'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got obs=%h cnt=%0d err=%b halted=%b want obs=0 cnt=0 err=0 halted=0",
               obs(), instr_count, err, halted);
    end
    reset = 1'b0;
    exp_cnt = 0;
    tick();
    #1;
    total++;
    if (obs() !== 19'h0) begin
      bad++;
      $display("FAIL idle_hold: got %h want 0", obs());
    end
  endtask

  task automatic test_add();
    logic [18:0] e [5];
    e = '{ex(S_IDLE, B_NONE, 2'd0, 2'd0, ALU_ADD),
          ex(S_FETCH, B_PCW | B_IRW | B_MR, SRCB_FOUR, PC_ALU, ALU_ADD),
          ex(S_DECODE, B_NONE, 2'd0, 2'd0, ALU_ADD),
          ex(S_EXEC, B_ASA, SRCB_REG, 2'd0, ALU_ADD),
          ex(S_WB, B_RW | B_RD, 2'd0, 2'd0, ALU_ADD)};
    bus.opcode = OP_RTYPE; bus.funct = F_ADD; bus.mem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) start = 1'b0;
      #1;
      total++;
      if (obs() !== e[i]) begin
        bad++;
        $display("FAIL add_cycle%0d: got %h want %h", i, obs(), e[i]);
      end
      tick();
    end
    exp_cnt++;
    #1;
    total++;
    if (state !== 3'd0 || instr_count !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL add_retire: got state=%0d cnt=%0d want state=0 cnt=%0d", state, instr_count, exp_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [5:0] op [5];
    logic [5:0] fn [5];
    alu_op_t    aop [5];
    logic       rt;
    op  = '{OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_RTYPE, OP_ADDI};
    fn  = '{F_SUB, F_AND, F_OR, F_SLT, 6'h00};
    aop = '{ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_ADD};
    start = 1'b1; bus.mem_ready = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.opcode = op[i]; bus.funct = fn[i];
      rt = (i < 4);
      #1;
      total++;
      if (obs() !== ex(S_FETCH, B_PCW | B_IRW | B_MR, SRCB_FOUR, PC_ALU, ALU_ADD)) begin
        bad++;
        $display("FAIL b2b%0d_fetch: got %h", i, obs());
      end
      tick();
      tick();
      total++;
      if (obs() !== ex(S_EXEC, B_ASA, rt ? SRCB_REG : SRCB_IMM, 2'd0, aop[i])) begin
        bad++;
        $display("FAIL b2b%0d_exec: got %h want %h", i, obs(),
                 ex(S_EXEC, B_ASA, rt ? SRCB_REG : SRCB_IMM, 2'd0, aop[i]));
      end
      tick();
      if (i == 4) start = 1'b0;
      #1;
      total++;
      if (obs() !== ex(S_WB, rt ? (B_RW | B_RD) : B_RW, 2'd0, 2'd0, ALU_ADD)) begin
        bad++;
        $display("FAIL b2b%0d_wb: got %h", i, obs());
      end
      tick();
    end
    exp_cnt += 5;
    total++;
    if (state !== 3'd0 || instr_count !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL b2b_retire: got state=%0d cnt=%0d want state=0 cnt=%0d", state, instr_count, exp_cnt);
    end
  endtask

  task automatic test_lw_wait();
    logic [18:0] e [9];
    logic        mr [9];
    e = '{ex(S_IDLE, B_NONE, 2'd0, 2'd0, ALU_ADD),
          ex(S_FETCH, B_PCW | B_IRW | B_MR, SRCB_FOUR, PC_ALU, ALU_ADD),
          ex(S_DECODE, B_NONE, 2'd0, 2'd0, ALU_ADD),
          ex(S_EXEC, B_ASA, SRCB_IMM, 2'd0, ALU_ADD),
          ex(S_MEM, B_IORD | B_MR, 2'd0, 2'd0, ALU_ADD),
          ex(S_MEM, B_IORD | B_MR, 2'd0, 2'd0, ALU_ADD),
          ex(S_MEM, B_IORD | B_MR, 2'd0, 2'd0, ALU_ADD),
          ex(S_MEM, B_IORD | B_MR, 2'd0, 2'd0, ALU_ADD),
          ex(S_WB, B_RW | B_M2R, 2'd0, 2'd0, ALU_ADD)};
    mr = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    bus.opcode = OP_LW; bus.funct = 6'h05; start = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.mem_ready = mr[i];
      if (i == 8) start = 1'b0;
      #1;
      total++;
      if (obs() !== e[i]) begin
        bad++;
        $display("FAIL lw_cycle%0d: got %h want %h", i, obs(), e[i]);
      end
      tick();
    end
    exp_cnt++;
    total++;
    if (state !== 3'd0 || instr_count !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL lw_retire: got state=%0d cnt=%0d want state=0 cnt=%0d", state, instr_count, exp_cnt);
    end
  endtask

  task automatic test_beq();
    logic [18:0] e [7];
    logic        z [7];
    e = '{ex(S_IDLE, B_NONE, 2'd0, 2'd0, ALU_ADD),
          ex(S_FETCH, B_PCW | B_IRW | B_MR, SRCB_FOUR, PC_ALU, ALU_ADD),
          ex(S_DECODE, B_NONE, 2'd0, 2'd0, ALU_ADD),
          ex(S_EXEC, B_PCW | B_ASA, SRCB_REG, PC_BRANCH, ALU_SUB),
          ex(S_FETCH, B_PCW | B_IRW | B_MR, SRCB_FOUR, PC_ALU, ALU_ADD),
          ex(S_DECODE, B_NONE, 2'd0, 2'd0, ALU_ADD),
          ex(S_EXEC, B_ASA, SRCB_REG, PC_BRANCH, ALU_SUB)};
    z = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bus.opcode = OP_BEQ; bus.mem_ready = 1'b1; start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.zero = z[i];
      if (i == 6) start = 1'b0;
      #1;
      total++;
      if (obs() !== e[i]) begin
        bad++;
        $display("FAIL beq_cycle%0d: got %h want %h", i, obs(), e[i]);
      end
      tick();
    end
    exp_cnt += 2;
    total++;
    if (state !== 3'd0 || instr_count !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL beq_retire: got state=%0d cnt=%0d want state=0 cnt=%0d", state, instr_count, exp_cnt);
    end
  endtask

  task automatic test_jump();
    bus.opcode = OP_J; bus.mem_ready = 1'b1; bus.zero = 1'b0; start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    #1;
    total++;
    if (obs() !== ex(S_DECODE, B_PCW, 2'd0, PC_JUMP, ALU_ADD)) begin
      bad++;
      $display("FAIL jump_decode: got %h want %h", obs(), ex(S_DECODE, B_PCW, 2'd0, PC_JUMP, ALU_ADD));
    end
    tick();
    exp_cnt++;
    total++;
    if (state !== 3'd0 || instr_count !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL jump_retire: got state=%0d cnt=%0d want state=0 cnt=%0d", state, instr_count, exp_cnt);
    end
  endtask

  task automatic test_sw_start_drop();
    logic [18:0] e [7];
    logic        mr [7];
    e = '{ex(S_IDLE, B_NONE, 2'd0, 2'd0, ALU_ADD),
          ex(S_FETCH, B_PCW | B_IRW | B_MR, SRCB_FOUR, PC_ALU, ALU_ADD),
          ex(S_DECODE, B_NONE, 2'd0, 2'd0, ALU_ADD),
          ex(S_EXEC, B_ASA, SRCB_IMM, 2'd0, ALU_ADD),
          ex(S_MEM, B_IORD | B_MW, 2'd0, 2'd0, ALU_ADD),
          ex(S_MEM, B_IORD | B_MW, 2'd0, 2'd0, ALU_ADD),
          ex(S_MEM, B_IORD | B_MW, 2'd0, 2'd0, ALU_ADD)};
    mr = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    bus.opcode = OP_SW; start = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.mem_ready = mr[i];
      if (i == 4) start = 1'b0;
      #1;
      total++;
      if (obs() !== e[i]) begin
        bad++;
        $display("FAIL sw_cycle%0d: got %h want %h", i, obs(), e[i]);
      end
      tick();
    end
    exp_cnt++;
    total++;
    if (state !== 3'd0 || instr_count !== 16'(exp_cnt)) begin
      bad++;
      $display("FAIL sw_retire: got state=%0d cnt=%0d want state=0 cnt=%0d", state, instr_count, exp_cnt);
    end
  endtask

  task automatic test_reset_fetch();
    bus.opcode = OP_LW; bus.mem_ready = 1'b0; start = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (obs() !== ex(S_FETCH, B_MR, 2'd0, 2'd0, ALU_ADD)) begin
        bad++;
        $display("FAIL fetch_wait%0d: got %h", i, obs());
      end
      tick();
    end
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (obs() !== 19'h0 || instr_count !== 16'd0 || count4 !== 4'd0) begin
      bad++;
      $display("FAIL async_reset: got obs=%h cnt=%0d cnt4=%0d want 0", obs(), instr_count, count4);
    end
    start = 1'b0;
    #1;
    reset = 1'b0;
    exp_cnt = 0;
    #1;
    total++;
    if (obs() !== 19'h0) begin
      bad++;
      $display("FAIL post_reset_quiet: got %h want 0", obs());
    end
    tick();
  endtask

  task automatic test_wrap();
    bus.opcode = OP_J; bus.mem_ready = 1'b1; start = 1'b1;
    tick();
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 16) start = 1'b0;
      tick();
      if (k == 15) begin
        total++;
        if (count4 !== 4'd15 || instr_count !== 16'd15) begin
          bad++;
          $display("FAIL wrap_pre: got cnt4=%0d cnt=%0d want 15 15", count4, instr_count);
        end
      end
    end
    exp_cnt = 16;
    total++;
    if (count4 !== 4'd0 || instr_count !== 16'(exp_cnt) || state !== 3'd0) begin
      bad++;
      $display("FAIL wrap: got cnt4=%0d cnt=%0d state=%0d want 0 16 0", count4, instr_count, state);
    end
  endtask

  task automatic test_halt();
    bus.opcode = OP_HALT; bus.mem_ready = 1'b1; start = 1'b1;
    tick();
    tick();
    #1;
    total++;
    if (obs() !== ex(S_DECODE, B_NONE, 2'd0, 2'd0, ALU_ADD)) begin
      bad++;
      $display("FAIL halt_decode: got %h", obs());
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      start = i[0];
      bus.mem_ready = ~i[0];
      #1;
      total++;
      if (obs() !== ex(S_HALT, B_NONE, 2'd0, 2'd0, ALU_ADD) || halted !== 1'b1 || err !== 1'b0
          || instr_count !== 16'(exp_cnt)) begin
        bad++;
        $display("FAIL halt_sticky%0d: got obs=%h halted=%b err=%b cnt=%0d want state=6 halted=1 err=0 cnt=%0d",
                 i, obs(), halted, err, instr_count, exp_cnt);
      end
      tick();
    end
    start = 1'b0;
    reset = 1'b1;
    #1;
    reset = 1'b0;
    exp_cnt = 0;
    tick();
    total++;
    if (state !== 3'd0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_exit: got state=%0d halted=%b want 0 0", state, halted);
    end
  endtask

  task automatic test_illegal();
    logic [5:0] op [2];
    logic [5:0] fn [2];
    op = '{6'h11, OP_RTYPE};
    fn = '{6'h00, 6'h21};
    for (int i = 0; i < 2; i++) begin
      bus.opcode = op[i]; bus.funct = fn[i]; bus.mem_ready = 1'b1; start = 1'b1;
      tick();
      tick();
      #1;
      total++;
      if (state !== 3'd2 || err !== 1'b0) begin
        bad++;
        $display("FAIL illegal%0d_decode: got state=%0d err=%b want 2 0", i, state, err);
      end
      tick();
      total++;
      if (obs() !== ex(S_HALT, B_NONE, 2'd0, 2'd0, ALU_ADD) || halted !== 1'b1 || err !== 1'b1) begin
        bad++;
        $display("FAIL illegal%0d_halt: got obs=%h halted=%b err=%b want state=6 halted=1 err=1",
                 i, obs(), halted, err);
      end
      start = 1'b0;
      reset = 1'b1;
      #1;
      reset = 1'b0;
      total++;
      if (err !== 1'b0 || state !== 3'd0) begin
        bad++;
        $display("FAIL illegal%0d_clear: got err=%b state=%0d want 0 0", i, err, state);
      end
      tick();
    end
  endtask

  // Inputs are driven with blocking assignments just after each rising edge.
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_lw_wait();
    test_beq();
    test_jump();
    test_sw_start_drop();
    test_reset_fetch();
    test_wrap();
    test_halt();
    test_illegal();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_ctrl.md
MIPS_CTRL -- requirements
Module: mips_ctrl

Interface
REQ-001 Parameter CNT_W, default 16: width of retired-instruction counter.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  run enable (board switch); level-sensitive.
REQ-005 opcode  input  6  IR[31:26] from datapath.
REQ-006 funct  input  6  IR[5:0] from datapath.
REQ-007 zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory access complete this cycle.
REQ-009 pc_write, ir_write, reg_write, mem_read, mem_write  output  1 each  datapath strobes.
REQ-010 iord, reg_dst, mem_to_reg, alu_src_a  output  1 each  datapath mux selects.
REQ-011 alu_src_b  output  2  0=regB, 1=const 4, 2=sign-ext imm.
REQ-012 pc_src  output  2  0=ALU result, 1=branch target, 2=jump target.
REQ-013 alu_op  output  3  ADD=0, SUB=1, AND=2, OR=3, SLT=4.
REQ-014 state  output  3  current FSM state (LED debug).
REQ-015 halted, err  output  1 each  stop indication; err = illegal opcode/funct.
REQ-016 instr_count  output  CNT_W  retired instructions.

Function
REQ-017 States IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; 7 unused -> IDLE next cycle.
REQ-018 Strobes/selects default 0 (alu_op ADD) in every state unless stated; all outputs decoded from state, opcode, funct, zero, mem_ready.
REQ-019 IDLE: start=1 -> FETCH, else stay.
REQ-020 FETCH: mem_read=1, iord=0; mem_ready=0 -> stay; mem_ready=1 -> ir_write=1, pc_write=1, alu_src_a=0, alu_src_b=1, pc_src=0 same cycle, -> DECODE.
REQ-021 DECODE (1 cycle): opcode 0x3F -> HALT; unsupported opcode or R-type funct -> HALT with err set; j (0x02) -> pc_write=1, pc_src=2, retire; other legal -> EXEC.
REQ-022 Legal: R-type op 0 with funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A; addi 0x08; lw 0x23; sw 0x2B; beq 0x04; j 0x02; halt 0x3F.
REQ-023 EXEC: alu_src_a=1; R-type: alu_src_b=0, alu_op from funct, -> WB; addi/lw/sw: alu_src_b=2, ADD, addi -> WB, lw/sw -> MEM; beq: alu_src_b=0, SUB, pc_src=1, pc_write=zero, retire.
REQ-024 MEM: iord=1; lw mem_read=1, sw mem_write=1, held until mem_ready=1; then lw -> WB, sw retires.
REQ-025 WB: reg_write=1; reg_dst=1 for R-type only; mem_to_reg=1 for lw only; retire.
REQ-026 Retire: instr_count increments by 1, wraps 2^CNT_W-1 -> 0; next state FETCH if start=1, else IDLE.
REQ-027 start deassert mid-instruction has no effect until retirement.
REQ-028 HALT sticky: no strobes, halted=1, count frozen; exit only via reset.
REQ-029 mem_ready ignored outside FETCH/MEM.

Reset
REQ-030 reset=1 forces immediately: state IDLE, instr_count 0, err 0, halted 0, all strobes 0.
REQ-031 Reset during MEM/FETCH wait aborts access; no strobe asserted in first cycle after release.

Structure
REQ-032 Package mips_pkg holds state encoding, opcode/funct constants, alu_op codes, mux-select codes; shared with datapath.
REQ-033 One sub-module mips_alu_dec: combinational funct/opcode -> alu_op plus legal flag.
REQ-034 State register and instr_count sole sequential elements; err registered on DECODE->HALT.

Verification
REQ-035 add (op 0, funct 0x20), mem_ready=1 in fetch -> FETCH,DECODE,EXEC,WB, reg_write=1 with reg_dst=1 in WB, count 0->1.
REQ-036 lw with mem_ready delayed 3 cycles in MEM -> mem_read held 4 cycles, then WB mem_to_reg=1; 6+3 cycles total.
REQ-037 beq zero=1 then zero=0 -> pc_write=1 pc_src=1 first, pc_write=0 second; both retire in 3 cycles.
REQ-038 opcode 0x3F -> HALT, halted=1, err=0, count frozen despite start toggling; op 0x11 -> HALT, err=1.
REQ-039 start=0 during sw MEM wait -> sw completes, count+1, then IDLE; reset asserted in FETCH wait -> IDLE, count 0 asynchronously.
REQ-040 CNT_W=4, 16 retirements -> instr_count wraps to 0.
